option_feeder: RTL and testbench
================================

// Module: option_feeder
// PURPOSE
//  Upstream stage of the solver. Holds every candidate line option in a circular
//  buffer and streams them to the solver: per line, one index beat, then that
//  line's options. Options the solver flags with put_back_to_FIFO are recirculated;
//  all other options are dropped. Also maintains per-line option counts and
//  detects solved and stuck (no-progress) conditions.
// PARAMETERS
//  SIZE   3   board is SIZE x SIZE; option width; 2*SIZE lines (rows 0..SIZE-1, cols SIZE..2*SIZE-1)
//  DEPTH  64  option buffer entries (power of 2)
//  LW     $clog2(2*SIZE)  line-index width (localparam)
// PORTS
//  clk               in   1            clock
//  rst               in   1            async active-high reset
//  load_valid        in   1            load beat valid
//  load_ready        out  1            buffer can accept a load beat (= !full, LOAD/IDLE only)
//  load_line         in   LW           line the loaded option belongs to
//  load_option       in   SIZE         loaded option bits
//  load_last         in   1            final load beat
//  option            out  SIZE         index beat (line zero-extended) or option beat
//  valid_op          out  1            option/index valid this cycle
//  started           out  1            high with the first index beat of the run only
//  old_options_amnt  out  [2*SIZE-1:0][6:0]  live option count per line
//  put_back_to_FIFO  in   1            solver: keep option emitted the previous cycle
//  solved            in   1            solver: board solved
//  busy/done/stuck   out  1 each       run in progress / solved / no progress in a full pass
// BEHAVIOUR
//  Reset: FSM=IDLE, buffer empty, counts 0; option=0, valid_op=0, started=0, done=0,
//   stuck=0, busy=0, load_ready=1.
//  Buffer entry = {line, option}. Loads push in order; the loader groups options by line, ascending.
//  FSM: IDLE -(load_valid)-> LOAD -(load_valid&load_last accepted)-> RUN -> DONE | STUCK.
//   Load beats are accepted in IDLE/LOAD when load_valid&load_ready; each increments count[load_line].
//   Load beats are ignored in all other states.
//  RUN, one beat per cycle, registered outputs:
//   - Head line != cur_line (or first beat): emit index beat, no pop, cur_line<=head line.
//   - Else pop head, emit option beat, remember {line,option} in 1-deep pend reg.
//   - At t+1 after an option beat: put_back=1 -> push pend to tail; put_back=0 -> count[line]--.
//     At most one push per cycle; pop and push in the same cycle are legal.
//   - put_back is sampled only the cycle after an option beat; otherwise ignored.
//  Pass boundary: an index beat whose line <= previous index-beat line.
//   - At that beat, if no drop occurred since the last boundary (drop in the same cycle counts),
//     enter STUCK.
//   - The first boundary of a run only arms the tracker.
//  solved=1 in RUN: next cycle valid_op=0, done=1, FSM=DONE. A pending put_back that cycle is
//   still applied. solved has priority over the STUCK check.
//  DONE/STUCK hold until reset; busy=1 only in RUN.
//  Empty buffer in RUN: enter STUCK.
//  Counts saturate at 0 and 127.
//  rst mid-run clears everything asynchronously; no beat is emitted afterwards.
// TESTING
//  3x3 load (r0:110,011 r1:100,010,001 r2:101 c0:101 c1:110,011 c2:100,010,001) ->
//   first beats 000(started=1),110,011,001,100,010,001,010,101,011,...; counts 2,3,1,1,2,3.
//  Same load, put_back=1 always -> second pass identical to first; stuck=1 at third line-0 index beat.
//  put_back=0 after 011 of row0 -> count[0]=1 next cycle; next pass row0 emits 000,110 only.
//  solved=1 mid-run -> next cycle valid_op=0, done=1, busy=0; outputs frozen thereafter.
//  DEPTH=4, 6 load beats -> load_ready=0 after 4th accepted; beats 5-6 not stored.
//  rst asserted mid-pass -> same cycle valid_op=0, counts 0, FSM IDLE; a fresh load runs cleanly.

Source files
------------

// File: rtl/option_feeder_if.sv
// Option feeder bus: the load channel into the feeder plus the option stream
// and solver feedback going out of it.
//
// Handshake: a load beat transfers on a rising clk edge where load_valid and
// load_ready are both high; the master holds load_line/option/last stable while
// load_valid is high. The option stream has no backpressure: valid_op marks one
// beat for exactly one cycle, and the solver answers an option beat with
// put_back_to_FIFO during the following cycle.
interface option_feeder_if #(
  parameter int SIZE = 3
);
  localparam int LW = $clog2(2 * SIZE);

  logic            load_valid;
  logic            load_ready;
  logic [LW-1:0]   load_line;
  logic [SIZE-1:0] load_option;
  logic            load_last;
  logic [SIZE-1:0] option;
  logic            valid_op;
  logic            started;
  logic            put_back_to_FIFO;
  logic            solved;

  // Solver / loader side
  modport master (
    output load_valid, load_line, load_option, load_last, put_back_to_FIFO, solved,
    input  load_ready, option, valid_op, started
  );

  // Feeder side
  modport slave (
    input  load_valid, load_line, load_option, load_last, put_back_to_FIFO, solved,
    output load_ready, option, valid_op, started
  );
endinterface

// File: rtl/option_feeder.sv
// Option feeder: circular buffer of {line, option} entries streamed to the
// solver as an index beat per line followed by that line's options. Options the
// solver keeps are recirculated to the tail, the rest are dropped and counted
// off. A full pass without a drop, or an empty buffer, ends the run as stuck.
module option_feeder #(
  parameter int SIZE  = 3,
  parameter int DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  option_feeder_if.slave         bus,
  output logic [2*SIZE-1:0][6:0] old_options_amnt,
  output logic                   busy,
  output logic                   done,
  output logic                   stuck,
  output logic [2:0]             state_dbg
);
  localparam int LW = $clog2(2 * SIZE);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = LW + SIZE;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_STUCK = 3'd4
  } state_t;

  state_t state, state_n;

  // Circular buffer
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic [EW-1:0]   head;
  logic [LW-1:0]   head_line;
  logic [SIZE-1:0] head_opt;

  // Run tracking
  logic [LW-1:0]   cur_line;    // line of the most recent index beat
  logic            first_beat;  // next index beat is the first of the run
  logic            armed;       // first pass boundary already seen
  logic            dropped;     // a drop happened since the last boundary
  logic            vis_opt;     // beat on the outputs now is an option beat
  logic [EW-1:0]   vis_entry;
  logic            pend_valid;  // option awaiting the solver's put_back answer
  logic [EW-1:0]   pend_entry;
  logic [LW-1:0]   pend_line;

  // Per-cycle actions
  logic            load_acc, push_pend, push, pop, drop;
  logic            emit_idx, emit_opt, boundary;
  logic [EW-1:0]   push_entry;

  assign fifo_full      = (fifo_cnt == (AW+1)'(DEPTH));
  assign fifo_empty     = (fifo_cnt == '0);
  assign head           = mem[rd_ptr];
  assign head_line      = head[EW-1:SIZE];
  assign head_opt       = head[SIZE-1:0];
  assign pend_line      = pend_entry[EW-1:SIZE];
  assign bus.load_ready = ((state == S_IDLE) || (state == S_LOAD)) && !fifo_full;
  assign load_acc       = bus.load_valid && bus.load_ready;
  assign push           = load_acc | push_pend;
  assign push_entry     = load_acc ? {bus.load_line, bus.load_option} : pend_entry;
  assign busy           = (state == S_RUN);
  assign state_dbg      = state;

  // Next state and per-cycle buffer/stream actions
  always_comb begin
    state_n   = state;
    push_pend = 1'b0;
    drop      = 1'b0;
    pop       = 1'b0;
    emit_idx  = 1'b0;
    emit_opt  = 1'b0;
    boundary  = 1'b0;
    case (state)
      S_IDLE, S_LOAD: begin
        if (load_acc && bus.load_last) state_n = S_RUN;
        else if (bus.load_valid)       state_n = S_LOAD;
      end
      S_RUN: begin
        // The solver's answer for the previous option beat is applied even
        // when the run ends this cycle.
        if (pend_valid) begin
          if (bus.put_back_to_FIFO) push_pend = 1'b1;
          else                      drop      = 1'b1;
        end
        if (bus.solved) begin
          state_n = S_DONE;
        end else if (fifo_empty) begin
          // Wait while an option is still out with the solver or coming back.
          if (!push_pend && !vis_opt) state_n = S_STUCK;
        end else if (first_beat || (head_line != cur_line)) begin
          emit_idx = 1'b1;
          if (!first_beat && (head_line <= cur_line)) begin
            boundary = 1'b1;
            if (armed && !(dropped || drop)) begin
              state_n  = S_STUCK;
              emit_idx = 1'b0;
            end
          end
        end else begin
          pop      = 1'b1;
          emit_opt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Buffer storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Registered stream outputs and pass tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.option   <= '0;
      bus.valid_op <= 1'b0;
      bus.started  <= 1'b0;
      done         <= 1'b0;
      stuck        <= 1'b0;
      cur_line     <= '0;
      first_beat   <= 1'b1;
      armed        <= 1'b0;
      dropped      <= 1'b0;
      vis_opt      <= 1'b0;
      vis_entry    <= '0;
      pend_valid   <= 1'b0;
      pend_entry   <= '0;
    end else begin
      bus.valid_op <= emit_idx | emit_opt;
      bus.started  <= emit_idx & first_beat;
      if (emit_idx) begin
        bus.option <= SIZE'(head_line);
        cur_line   <= head_line;
        first_beat <= 1'b0;
      end
      if (emit_opt) begin
        bus.option <= head_opt;
        vis_entry  <= head;
      end
      vis_opt    <= emit_opt;
      pend_valid <= vis_opt && (state_n == S_RUN);
      pend_entry <= vis_entry;
      if (boundary) begin
        armed   <= 1'b1;
        dropped <= 1'b0;
      end else if (drop) begin
        dropped <= 1'b1;
      end
      done  <= (state_n == S_DONE);
      stuck <= (state_n == S_STUCK);
    end
  end

  // Live option counts per line, saturating at 0 and 127
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_options_amnt <= '0;
    end else begin
      for (int i = 0; i < 2 * SIZE; i++) begin
        if (load_acc && (bus.load_line == LW'(i))) begin
          if (old_options_amnt[i] != 7'd127) old_options_amnt[i] <= old_options_amnt[i] + 7'd1;
        end else if (drop && (pend_line == LW'(i))) begin
          if (old_options_amnt[i] != 7'd0) old_options_amnt[i] <= old_options_amnt[i] - 7'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_option_feeder.sv
// Directed bench for option_feeder: 3x3 board load, recirculation, drops,
// solved, stuck (full pass and empty buffer), load back-pressure, async reset.
module tb_option_feeder;
  localparam int SIZE = 3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  option_feeder_if #(.SIZE(SIZE)) bus_a ();
  option_feeder_if #(.SIZE(SIZE)) bus_b ();

  logic [2*SIZE-1:0][6:0] amnt_a, amnt_b;
  logic busy_a, done_a, stuck_a, busy_b, done_b, stuck_b;
  logic [2:0] state_a, state_b;

  option_feeder #(.SIZE(SIZE), .DEPTH(64)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .old_options_amnt(amnt_a),
    .busy(busy_a), .done(done_a), .stuck(stuck_a), .state_dbg(state_a)
  );

  option_feeder #(.SIZE(SIZE), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .old_options_amnt(amnt_b),
    .busy(busy_b), .done(done_b), .stuck(stuck_b), .state_dbg(state_b)
  );

  // Board load: r0 r1 r2 c0 c1 c2
  logic [2:0] ld_line   [12] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2,
                                 3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd5};
  logic [2:0] ld_opt    [12] = '{3'b110, 3'b011, 3'b100, 3'b010, 3'b001, 3'b101,
                                 3'b101, 3'b110, 3'b011, 3'b100, 3'b010, 3'b001};
  // One full pass: index beat then options for each line
  logic [2:0] exp_beats [18] = '{3'd0, 3'b110, 3'b011,
                                 3'd1, 3'b100, 3'b010, 3'b001,
                                 3'd2, 3'b101,
                                 3'd3, 3'b101,
                                 3'd4, 3'b110, 3'b011,
                                 3'd5, 3'b100, 3'b010, 3'b001};
  // Pass after row0 option 011 was dropped
  logic [2:0] exp_p2    [17] = '{3'd0, 3'b110,
                                 3'd1, 3'b100, 3'b010, 3'b001,
                                 3'd2, 3'b101,
                                 3'd3, 3'b101,
                                 3'd4, 3'b110, 3'b011,
                                 3'd5, 3'b100, 3'b010, 3'b001};

  localparam logic [41:0] CNT_FULL  = {7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd2};
  localparam logic [41:0] CNT_DROP0 = {7'd3, 7'd2, 7'd1, 7'd1, 7'd3, 7'd1};

  int errors = 0;
  int checks = 0;

  // Scoreboard comparison
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: reset pulse, returns at a negedge with rst low
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Driver: full board load into dut_a; returns at the negedge after the last accept
  task automatic load_a();
    for (int i = 0; i < 12; i++) begin
      bus_a.load_valid  = 1'b1;
      bus_a.load_line   = ld_line[i];
      bus_a.load_option = ld_opt[i];
      bus_a.load_last   = (i == 11);
      @(negedge clk);
    end
    bus_a.load_valid = 1'b0;
    bus_a.load_last  = 1'b0;
  endtask

  initial begin
    bus_a.load_valid = 1'b0; bus_a.load_line = '0; bus_a.load_option = '0;
    bus_a.load_last = 1'b0; bus_a.put_back_to_FIFO = 1'b0; bus_a.solved = 1'b0;
    bus_b.load_valid = 1'b0; bus_b.load_line = '0; bus_b.load_option = '0;
    bus_b.load_last = 1'b0; bus_b.put_back_to_FIFO = 1'b0; bus_b.solved = 1'b0;

    // Reset state
    do_reset();
    check("rst_option", bus_a.option, 0);
    check("rst_valid_op", bus_a.valid_op, 0);
    check("rst_started", bus_a.started, 0);
    check("rst_flags", {busy_a, done_a, stuck_a}, 3'b000);
    check("rst_load_ready", bus_a.load_ready, 1);
    check("rst_counts", amnt_a, 0);
    check("rst_state", state_a, 0);

    // Small buffer: back-pressure after four accepted beats
    for (int i = 0; i < 6; i++) begin
      check($sformatf("b_ready%0d", i), bus_b.load_ready, (i < 4));
      bus_b.load_valid  = 1'b1;
      bus_b.load_line   = 3'(i / 2);
      bus_b.load_option = 3'b001;
      bus_b.load_last   = (i == 5);
      @(negedge clk);
    end
    bus_b.load_valid = 1'b0;
    bus_b.load_last  = 1'b0;
    check("b_counts", amnt_b, {7'd0, 7'd0, 7'd0, 7'd0, 7'd2, 7'd2});
    check("b_state_load", state_b, 1);

    // Keep everything: two identical passes, then stuck at the next line-0 index
    do_reset();
    bus_a.put_back_to_FIFO = 1'b1;
    load_a();
    check("a_state_run", state_a, 2);
    check("a_counts_loaded", amnt_a, CNT_FULL);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      check($sformatf("keep_beat%0d", k), {bus_a.valid_op, bus_a.option}, {1'b1, exp_beats[k % 18]});
      check($sformatf("keep_started%0d", k), bus_a.started, (k == 0));
      if (k == 5) check("keep_busy", busy_a, 1);
    end
    @(negedge clk);
    check("keep_stuck", {stuck_a, busy_a, done_a, bus_a.valid_op}, 4'b1000);
    check("keep_stuck_state", state_a, 4);
    check("keep_counts", amnt_a, CNT_FULL);

    // Drop row0 option 011: count falls, next pass row0 is 000,110 only
    do_reset();
    bus_a.put_back_to_FIFO = 1'b1;
    load_a();
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (k < 18) check($sformatf("drop_beat%0d", k), {bus_a.valid_op, bus_a.option}, {1'b1, exp_beats[k]});
      else        check($sformatf("drop_beat%0d", k), {bus_a.valid_op, bus_a.option}, {1'b1, exp_p2[k - 18]});
      if (k == 3) check("drop_cnt_before", amnt_a[0], 2);
      if (k == 4) check("drop_cnt_after", amnt_a[0], 1);
      bus_a.put_back_to_FIFO = (k != 3);
    end
    @(negedge clk);
    check("drop_stuck", {stuck_a, bus_a.valid_op}, 2'b10);
    check("drop_counts", amnt_a, CNT_DROP0);

    // Solved mid-run, with a drop answered in the same cycle
    do_reset();
    bus_a.put_back_to_FIFO = 1'b1;
    load_a();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("sol_beat%0d", k), bus_a.option, exp_beats[k]);
    end
    bus_a.solved = 1'b1;
    bus_a.put_back_to_FIFO = 1'b0;
    @(negedge clk);
    bus_a.solved = 1'b0;
    bus_a.put_back_to_FIFO = 1'b1;
    check("sol_flags", {bus_a.valid_op, done_a, busy_a, stuck_a}, 4'b0100);
    check("sol_cnt0", amnt_a[0], 1);
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("sol_frozen_out", {bus_a.valid_op, bus_a.option}, {1'b0, 3'b011});
    check("sol_frozen_cnt", amnt_a, CNT_DROP0);
    check("sol_state", {state_a, done_a}, {3'd3, 1'b1});

    // Single option, dropped: buffer empties and the run sticks
    do_reset();
    bus_a.put_back_to_FIFO = 1'b0;
    bus_a.load_valid = 1'b1; bus_a.load_line = 3'd0; bus_a.load_option = 3'b110; bus_a.load_last = 1'b1;
    @(negedge clk);
    bus_a.load_valid = 1'b0; bus_a.load_last = 1'b0;
    check("one_state_run", state_a, 2);
    @(negedge clk);
    check("one_idx", {bus_a.valid_op, bus_a.started, bus_a.option}, {2'b11, 3'd0});
    @(negedge clk);
    check("one_opt", {bus_a.valid_op, bus_a.started, bus_a.option}, {2'b10, 3'b110});
    @(negedge clk);
    check("one_wait", {bus_a.valid_op, busy_a, stuck_a}, 3'b010);
    @(negedge clk);
    check("one_stuck", {bus_a.valid_op, busy_a, stuck_a}, 3'b001);
    check("one_cnt", amnt_a[0], 0);

    // Asynchronous reset mid-pass, then a clean fresh run
    do_reset();
    bus_a.put_back_to_FIFO = 1'b1;
    load_a();
    for (int k = 0; k < 6; k++) @(negedge clk);
    check("mid_before", {bus_a.valid_op, bus_a.option}, {1'b1, exp_beats[5]});
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", bus_a.valid_op, 0);
    check("mid_rst_counts", amnt_a, 0);
    check("mid_rst_state", state_a, 0);
    check("mid_rst_ready", bus_a.load_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    load_a();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("fresh_beat%0d", k), {bus_a.valid_op, bus_a.started, bus_a.option},
            {1'b1, (k == 0), exp_beats[k]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
